// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   DATA_WIDTH / INSTR_WIDTH : address and instruction widths
//   NOP_INSTR                : addi x0,x0,0, shown to decode when nothing is buffered
//   PC_STEP                  : byte distance between sequential instructions
//   PC_ALIGN_MASK            : low address bits that must be zero in a PC
//   fetch_entry_t            : one buffered fetch, {pc, instr}
package fetch_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR     = 32'h0000_0013;
    localparam logic [DATA_WIDTH-1:0]  PC_STEP       = 32'd4;
    localparam logic [DATA_WIDTH-1:0]  PC_ALIGN_MASK = 32'h0000_0003;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Forces a byte address onto a word boundary.
    function automatic logic [DATA_WIDTH-1:0] align_pc(input logic [DATA_WIDTH-1:0] addr);
        return addr & ~PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer
// Small synchronous FIFO of fetch_entry_t between fetch and decode.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push         : write push_entry at the tail (ignored when full unless popping)
//   pop          : drop the head entry (ignored when empty)
//   flush        : discard every entry; wins over push and pop
//   push_entry   : entry to write
//   head_entry   : entry at the head (meaningful only when !empty)
//   count        : occupancy, 0..BUF_DEPTH
//   full, empty  : occupancy flags
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  fetch_entry_t                   push_entry,
    output fetch_entry_t                   head_entry,
    output logic [$clog2(BUF_DEPTH+1)-1:0] count,
    output logic                           full,
    output logic                           empty
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH+1);

    fetch_entry_t           mem [BUF_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic                   do_push;
    logic                   do_pop;

    assign full       = (count == CNT_W'(BUF_DEPTH));
    assign empty      = (count == '0);
    assign head_entry = mem[rd_ptr];

    // A push into a full buffer is only legal when the head leaves in the
    // same cycle; the tail then reuses the slot being vacated.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage is pure datapath; entries are only observed once count says so,
    // so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch: owns the PC, addresses the combinational instruction
// memory, and buffers {pc, instr} pairs for decode behind a valid/ready port.
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem_addr       : byte address to instruction memory (the PC register)
//   imem_instr      : instruction at imem_addr, same cycle
//   redirect_valid  : taken branch/jump from execute; flushes and restarts
//   redirect_pc     : redirect target (low two bits ignored)
//   out_valid       : head of the fetch buffer is valid
//   out_ready       : decode takes the head this cycle
//   out_instr       : head instruction, NOP_INSTR when empty
//   out_pc          : head PC, 0 when empty
//   out_pc_plus4    : out_pc + 4
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0]  RESET_PC  = 32'h0000_0000,
    parameter int                     BUF_DEPTH = 2,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [DATA_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_instr,
    input  logic                   redirect_valid,
    input  logic [DATA_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [DATA_WIDTH-1:0]  out_pc,
    output logic [DATA_WIDTH-1:0]  out_pc_plus4
);

    logic [DATA_WIDTH-1:0]          pc;
    logic                           pop;
    logic                           push;
    logic                           buf_full;
    logic                           buf_empty;
    logic [$clog2(BUF_DEPTH+1)-1:0] buf_count;
    fetch_entry_t                   new_entry;
    fetch_entry_t                   head_entry;

    assign imem_addr = pc;

    // A fetch happens whenever there is room, counting the slot freed by a
    // pop in the same cycle. Redirect suppresses it: the word at the old PC
    // is on the wrong path.
    assign pop  = out_valid & out_ready;
    assign push = ~redirect_valid & (~buf_full | pop);

    assign new_entry.pc    = pc;
    assign new_entry.instr = imem_instr;

    // PC register: redirect beats sequential advance; a stall holds the PC
    // so the memory address stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= align_pc(redirect_pc);
        end else if (push) begin
            pc <= pc + PC_STEP;
        end
    end

    fetch_buffer #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .push_entry (new_entry),
        .head_entry (head_entry),
        .count      (buf_count),
        .full       (buf_full),
        .empty      (buf_empty)
    );

    // Outputs come only from registered buffer state. When empty, decode is
    // shown a NOP at PC 0 so nothing stale leaks through.
    always_comb begin
        out_valid = ~buf_empty;
        out_instr = NOP_INSTR;
        out_pc    = '0;
        if (!buf_empty) begin
            out_instr = head_entry.instr;
            out_pc    = head_entry.pc;
        end
        out_pc_plus4 = out_pc + PC_STEP;
    end

endmodule
